tape_recorder: RTL and testbench
================================

TAPE_RECORDER -- requirements
Module: tape_recorder

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 24: clk_sys frequency in MHz, used to derive a 1 us tick.
REQ-002 SHALL have parameter MIN_US, default 100: rising-edge periods below this are glitches.
REQ-003 SHALL have parameter THRESH_US, default 312: periods below this are bit 1, periods at or above it are bit 0.
REQ-004 SHALL have parameter MAX_US, default 1000: periods above this are loss of signal.
REQ-005 SHALL have port clk_sys  in  1  system clock; the block uses one clock only.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  in  1  cassette relay (motor) on; capture runs only while it is high.
REQ-008 SHALL have port clear  in  1  one-cycle pulse that rewinds the capture buffer.
REQ-009 SHALL have port tape_out  in  1  asynchronous tape-out bit from the machine.
REQ-010 SHALL have port wr_addr  out  16  buffer write address.
REQ-011 SHALL have port wr_data  out  8  decoded byte.
REQ-012 SHALL have port wr_en  out  1  one-cycle buffer write strobe.
REQ-013 SHALL have port tape_end  out  16  address of the last byte written.
REQ-014 SHALL have port byte_count  out  17  number of bytes captured.
REQ-015 SHALL have port full  out  1  buffer exhausted (sticky).
REQ-016 SHALL have port parity_err  out  1  a parity mismatch was seen (sticky).
REQ-017 SHALL have port active  out  1  a byte is being decoded (FSM outside HUNT).

Function
REQ-018 tape_out SHALL pass through a 2-flop synchronizer; a rising edge is detected on the synchronized signal, 3 clk_sys of latency.
REQ-019 Tick generator: one-cycle tick every CLK_MHZ clk_sys cycles; free-running; cleared by reset only.
REQ-020 Period counter: 11-bit, µs resolution, +1 per tick, saturates at 2047; zeroed on every accepted edge.
REQ-021 Edge with period < MIN_US: ignored; counter not zeroed; no bit produced.
REQ-022 Accepted edge: classifies bit = (period < THRESH_US) ? 1 : 0; classification happens in the cycle after the edge.
REQ-023 Loss of signal (period > MAX_US without an edge, or saturation): FSM -> HUNT; partial byte discarded, never written.
REQ-024 FSM states: HUNT, DATA, PARITY, STOP.
REQ-025 HUNT: counts consecutive 1 bits (ones_seen flag); a 0 bit with ones_seen=1 -> DATA with bit index 0; a 0 bit with ones_seen=0 stays in HUNT.
REQ-026 DATA: shift in 8 bits LSB first; after bit index 7 -> PARITY.
REQ-027 PARITY: expected parity bit = 1 if the data has an even number of ones (odd overall parity); on mismatch parity_err<=1.
REQ-028 PARITY: on the parity bit, wr_en pulses for exactly 1 cycle, in the cycle after classification, with wr_addr=ptr and wr_data=byte; the byte is written even when parity is wrong; then -> STOP.
REQ-029 Write bookkeeping: tape_end<=ptr; byte_count+1; ptr+1.
REQ-030 Full: if ptr was 0xFFFF when written, full<=1 and ptr holds; while full=1, wr_en is suppressed and byte_count is frozen at 65536.
REQ-031 STOP: a 1 bit -> HUNT with ones_seen=1; a 0 bit -> HUNT with ones_seen=0 (framing slip, no error flag).
REQ-032 en=0: FSM forced to HUNT, ones_seen=0, period counter held at 0, partial byte discarded; ptr, tape_end, byte_count, full and parity_err retained.
REQ-033 clear: ptr=0, byte_count=0, tape_end=0, full=0, parity_err=0, FSM -> HUNT.
REQ-034 clear coinciding with a pending write: clear wins and the write is dropped.
REQ-035 wr_addr and wr_data SHALL hold their last values while wr_en=0.

Reset
REQ-036 reset SHALL give: FSM=HUNT, ones_seen=0, ptr=0, wr_addr=0, wr_data=0, wr_en=0, tape_end=0, byte_count=0, full=0, parity_err=0, active=0, counters=0, synchronizer=0.
REQ-037 reset SHALL override en, clear and edges in the same cycle; an in-flight byte is discarded.

Verification (CLK_MHZ=24; short period 208 us = 4992 clk, long period 416 us = 9984 clk)
REQ-038 Byte decode: en=1, 4 short periods, 1 long (start), data 0x16 LSB first (L,S,S,L,S,L,L,L), parity L, 1 short -> one wr_en with wr_addr=0, wr_data=0x16, byte_count=1, tape_end=0, parity_err=0.
REQ-039 Parity error: same stream as REQ-038 but parity bit short -> 0x16 written at address 0, parity_err=1 until clear.
REQ-040 Glitch and timeout: 50 us pulses inside a data bit -> decoding unaffected; a 1.2 ms gap after 4 data bits -> no wr_en, FSM=HUNT, active=0.
REQ-041 Relay drop: en falls mid-DATA -> no write; after en returns, the next full frame is written at address 1 following one prior byte.
REQ-042 Full: preload ptr=0xFFFF via 65535 frames, or force ptr in the bench -> the next frame writes at 0xFFFF and full=1; the following frame gives no wr_en and byte_count=65536.
REQ-043 Clear/reset collision: clear asserted in the write cycle -> wr_en=0 and all outputs read 0; reset asserted mid-frame -> every output equals its REQ-036 value on the next cycle.

Source files
------------

// File: rtl/tape_recorder_if.sv
// Buffer write port of the tape recorder: address, decoded byte and a one-cycle strobe.
interface tape_recorder_if;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_en;

   modport master (output wr_addr, output wr_data, output wr_en);
   modport slave  (input wr_addr, input wr_data, input wr_en);
endinterface

// File: rtl/tape_recorder.sv
// Cassette tape-out capture: measures rising-edge periods in microseconds, decodes
// start/data/parity/stop frames and writes each byte into a 64 KiB capture buffer.
module tape_recorder #(
   parameter int CLK_MHZ   = 24,
   parameter int MIN_US    = 100,
   parameter int THRESH_US = 312,
   parameter int MAX_US    = 1000
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   clear,
   input  logic                   tape_out,
   tape_recorder_if.master        wr,
   output logic [15:0]            tape_end,
   output logic [16:0]            byte_count,
   output logic                   full,
   output logic                   parity_err,
   output logic                   active
);

   localparam int TICK_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLK_MHZ - 1);
   localparam logic [10:0]       PERIOD_MAX = 11'h7FF;

   typedef enum logic [1:0] {S_HUNT, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v == PERIOD_MAX) ? v : v + 11'd1;
   endfunction

   // Odd overall parity: the parity bit is 1 when the data holds an even number of ones.
   function automatic logic odd_parity_bit(input logic [7:0] d);
      return ~^d;
   endfunction

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              sync_p0, sync_p1, sync_p2;
   logic              edge_p2, accept_p2, timeout_p2;
   logic [10:0]       period_p2;
   logic              bit_vld_p3, bit_p3;
   state_t            state;
   logic              ones_seen;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic [15:0]       ptr;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
         tick     <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
         tick     <= 1'b0;
      end
   end

   // Stages p0..p2: synchronizer and rising-edge detect
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= tape_out;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign edge_p2    = sync_p1 & ~sync_p2;
   assign accept_p2  = edge_p2 && en && (int'(period_p2) >= MIN_US);
   assign timeout_p2 = (int'(period_p2) > MAX_US) || (period_p2 == PERIOD_MAX);

   // Glitch edges leave the period running so the next real edge still sees the full gap.
   always_ff @(posedge clk_sys) begin
      if (reset)          period_p2 <= '0;
      else if (!en)       period_p2 <= '0;
      else if (accept_p2) period_p2 <= '0;
      else if (tick)      period_p2 <= sat_inc(period_p2);
   end

   // Stage p3: bit classification
   always_ff @(posedge clk_sys) begin
      if (reset) bit_vld_p3 <= 1'b0;
      else       bit_vld_p3 <= accept_p2;
   end

   always_ff @(posedge clk_sys) begin
      bit_p3 <= (int'(period_p2) < THRESH_US);
   end

   // Stage p4: frame FSM and buffer write
   always_ff @(posedge clk_sys) begin
      wr.wr_en <= 1'b0;
      if (reset) begin
         state      <= S_HUNT;
         ones_seen  <= 1'b0;
         bit_idx    <= '0;
         ptr        <= '0;
         wr.wr_addr <= '0;
         wr.wr_data <= '0;
         tape_end   <= '0;
         byte_count <= '0;
         full       <= 1'b0;
         parity_err <= 1'b0;
      end else if (clear) begin
         state      <= S_HUNT;
         ones_seen  <= 1'b0;
         ptr        <= '0;
         wr.wr_addr <= '0;
         wr.wr_data <= '0;
         tape_end   <= '0;
         byte_count <= '0;
         full       <= 1'b0;
         parity_err <= 1'b0;
      end else if (!en || timeout_p2) begin
         state     <= S_HUNT;
         ones_seen <= 1'b0;
      end else if (bit_vld_p3) begin
         unique case (state)
            S_HUNT: begin
               if (bit_p3) begin
                  ones_seen <= 1'b1;
               end else if (ones_seen) begin
                  ones_seen <= 1'b0;
                  bit_idx   <= '0;
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               shreg   <= {bit_p3, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == 3'd7) state <= S_PARITY;
            end
            S_PARITY: begin
               if (bit_p3 != odd_parity_bit(shreg)) parity_err <= 1'b1;
               if (!full) begin
                  wr.wr_en   <= 1'b1;
                  wr.wr_addr <= ptr;
                  wr.wr_data <= shreg;
                  tape_end   <= ptr;
                  if (ptr == 16'hFFFF) begin
                     full       <= 1'b1;
                     byte_count <= 17'h10000;
                  end else begin
                     ptr        <= ptr + 16'd1;
                     byte_count <= byte_count + 17'd1;
                  end
               end
               state <= S_STOP;
            end
            S_STOP: begin
               ones_seen <= bit_p3;
               state     <= S_HUNT;
            end
         endcase
      end
   end

   assign active = (state != S_HUNT);

endmodule

// File: tb/tb_tape_recorder.sv
// Directed bench for tape_recorder: frame vectors from a table plus hand-written
// timeout, relay-drop, buffer-full, reset and clear-collision sequences.
module tb_tape_recorder;

   localparam int CLK = 1;
   localparam int S_US = 208;
   localparam int L_US = 416;

   logic        clk_sys = 1'b0;
   logic        reset, en, clear, tape_out;
   logic [15:0] tape_end;
   logic [16:0] byte_count;
   logic        full, parity_err, active;

   tape_recorder_if wbus();

   tape_recorder #(.CLK_MHZ(CLK)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .en         (en),
      .clear      (clear),
      .tape_out   (tape_out),
      .wr         (wbus),
      .tape_end   (tape_end),
      .byte_count (byte_count),
      .full       (full),
      .parity_err (parity_err),
      .active     (active)
   );

   always #5 clk_sys = ~clk_sys;

   int          checks = 0;
   int          failures = 0;
   int          wr_pulses = 0;
   logic [15:0] last_addr = '0;
   logic [7:0]  last_data = '0;

   always @(negedge clk_sys) begin
      if (wbus.wr_en === 1'b1) begin
         wr_pulses = wr_pulses + 1;
         last_addr = wbus.wr_addr;
         last_data = wbus.wr_data;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".wr_addr"},    32'(wbus.wr_addr), 32'd0);
      check({tag, ".wr_data"},    32'(wbus.wr_data), 32'd0);
      check({tag, ".wr_en"},      32'(wbus.wr_en),   32'd0);
      check({tag, ".tape_end"},   32'(tape_end),     32'd0);
      check({tag, ".byte_count"}, 32'(byte_count),   32'd0);
      check({tag, ".full"},       32'(full),         32'd0);
      check({tag, ".parity_err"}, 32'(parity_err),   32'd0);
      check({tag, ".active"},     32'(active),       32'd0);
   endtask

   // One period ends with a rising edge; the pulse falls 20 us in, optional 50 us glitch.
   task automatic period(input int us, input bit glitch);
      for (int i = 1; i <= us * CLK; i++) begin
         @(negedge clk_sys);
         if (i == 20 * CLK) tape_out = 1'b0;
         if (glitch && i == 50 * CLK) tape_out = 1'b1;
         if (glitch && i == 60 * CLK) tape_out = 1'b0;
      end
      tape_out = 1'b1;
   endtask

   task automatic send_head();
      period(1100, 1'b0);
      for (int i = 0; i < 4; i++) period(S_US, 1'b0);
      period(L_US, 1'b0);
   endtask

   task automatic send_bits(input logic [7:0] d, input int n, input bit glitch);
      for (int i = 0; i < n; i++) period(d[i] ? S_US : L_US, glitch);
   endtask

   task automatic send_parity(input logic [7:0] d, input bit bad);
      logic p;
      p = (~^d) ^ bad;
      period(p ? S_US : L_US, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad, input bit glitch);
      send_head();
      send_bits(d, 8, glitch);
      send_parity(d, bad);
      period(S_US, 1'b0);
      repeat (10) @(negedge clk_sys);
   endtask

   typedef struct {
      bit          clr;
      logic [7:0]  data;
      bit          bad;
      bit          glitch;
      logic [15:0] exp_addr;
      logic [16:0] exp_cnt;
      bit          exp_perr;
   } vec_t;

   vec_t vecs [4];
   int   base;

   initial begin
      vecs[0] = '{1'b0, 8'h16, 1'b0, 1'b0, 16'h0000, 17'd1, 1'b0};
      vecs[1] = '{1'b1, 8'h16, 1'b1, 1'b0, 16'h0000, 17'd1, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0001, 17'd2, 1'b1};
      vecs[3] = '{1'b1, 8'hA5, 1'b0, 1'b1, 16'h0000, 17'd1, 1'b0};

      reset = 1'b1; en = 1'b0; clear = 1'b0; tape_out = 1'b0;
      repeat (3) @(negedge clk_sys);
      check_all_zero("reset");
      reset = 1'b0;
      en = 1'b1;
      repeat (5) @(negedge clk_sys);

      for (int v = 0; v < 4; v++) begin
         if (vecs[v].clr) begin
            clear = 1'b1;
            @(negedge clk_sys);
            clear = 1'b0;
            check($sformatf("v%0d.cleared_count", v), 32'(byte_count), 32'd0);
            check($sformatf("v%0d.cleared_perr", v), 32'(parity_err), 32'd0);
         end
         base = wr_pulses;
         send_frame(vecs[v].data, vecs[v].bad, vecs[v].glitch);
         check($sformatf("v%0d.wr_cycles", v), 32'(wr_pulses - base), 32'd1);
         check($sformatf("v%0d.wr_addr", v), 32'(last_addr), 32'(vecs[v].exp_addr));
         check($sformatf("v%0d.wr_data", v), 32'(last_data), 32'(vecs[v].data));
         check($sformatf("v%0d.byte_count", v), 32'(byte_count), 32'(vecs[v].exp_cnt));
         check($sformatf("v%0d.tape_end", v), 32'(tape_end), 32'(vecs[v].exp_addr));
         check($sformatf("v%0d.parity_err", v), 32'(parity_err), 32'(vecs[v].exp_perr));
         check($sformatf("v%0d.full", v), 32'(full), 32'd0);
         check($sformatf("v%0d.hold_addr", v), 32'(wbus.wr_addr), 32'(vecs[v].exp_addr));
      end

      // Loss of signal after four data bits
      base = wr_pulses;
      send_head();
      send_bits(8'h5A, 4, 1'b0);
      repeat (6) @(negedge clk_sys);
      check("timeout.active_before", 32'(active), 32'd1);
      repeat (1200) @(negedge clk_sys);
      check("timeout.active_after", 32'(active), 32'd0);
      check("timeout.no_write", 32'(wr_pulses - base), 32'd0);
      check("timeout.byte_count", 32'(byte_count), 32'd1);

      // Relay drop mid-DATA, then a full frame lands at address 1
      send_head();
      send_bits(8'hC3, 3, 1'b0);
      repeat (6) @(negedge clk_sys);
      check("relay.active_before", 32'(active), 32'd1);
      en = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("relay.active_off", 32'(active), 32'd0);
      repeat (50) @(negedge clk_sys);
      en = 1'b1;
      check("relay.no_write", 32'(wr_pulses - base), 32'd0);
      send_frame(8'h3C, 1'b0, 1'b0);
      check("relay.wr_cycles", 32'(wr_pulses - base), 32'd1);
      check("relay.wr_addr", 32'(last_addr), 32'h0001);
      check("relay.wr_data", 32'(last_data), 32'h3C);
      check("relay.byte_count", 32'(byte_count), 32'd2);
      check("relay.tape_end", 32'(tape_end), 32'h0001);

      // Last buffer slot, then a frame with the buffer full
      force dut.ptr = 16'hFFFF;
      base = wr_pulses;
      send_frame(8'h81, 1'b0, 1'b0);
      check("full.wr_cycles", 32'(wr_pulses - base), 32'd1);
      check("full.wr_addr", 32'(last_addr), 32'hFFFF);
      check("full.wr_data", 32'(last_data), 32'h81);
      check("full.full", 32'(full), 32'd1);
      check("full.byte_count", 32'(byte_count), 32'h10000);
      check("full.tape_end", 32'(tape_end), 32'hFFFF);
      release dut.ptr;
      base = wr_pulses;
      send_frame(8'h42, 1'b0, 1'b0);
      check("full2.no_write", 32'(wr_pulses - base), 32'd0);
      check("full2.byte_count", 32'(byte_count), 32'h10000);
      check("full2.full", 32'(full), 32'd1);

      // Reset mid-frame, with clear and en also asserted
      base = wr_pulses;
      send_head();
      send_bits(8'h0F, 3, 1'b0);
      repeat (6) @(negedge clk_sys);
      check("rstmid.active_before", 32'(active), 32'd1);
      reset = 1'b1;
      clear = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      clear = 1'b0;
      check_all_zero("rstmid");
      check("rstmid.no_write", 32'(wr_pulses - base), 32'd0);

      // Clear in the exact cycle the parity write would be registered
      base = wr_pulses;
      send_head();
      send_bits(8'h16, 8, 1'b0);
      send_parity(8'h16, 1'b1);
      repeat (3) @(negedge clk_sys);
      clear = 1'b1;
      @(negedge clk_sys);
      clear = 1'b0;
      check_all_zero("clrcol");
      repeat (5) @(negedge clk_sys);
      check("clrcol.no_write", 32'(wr_pulses - base), 32'd0);
      check("clrcol.byte_count_late", 32'(byte_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
